// File: rtl/minion_soc_lite.sv
// Bring-up SoC: the sequencer sends "OK\r\n" over the UART, collects each echoed byte,
// logs it to shared memory, reads it back for checking, then raises u_break.
module minion_soc_lite #(
  parameter int          CLK_DIV     = 16,
  parameter logic [31:0] SHARED_BASE = 32'h0010_0000
) (
  input  logic        msoc_clk,
  input  logic        rst,
  output logic        uart_tx,
  input  logic        uart_rx,
  output logic        u_break,
  output logic [7:0]  to_led,
  input  logic [15:0] from_dip,
  input  logic        GPIO_SW_C,
  input  logic        GPIO_SW_W,
  input  logic        GPIO_SW_E,
  input  logic        GPIO_SW_N,
  input  logic        GPIO_SW_S,
  output logic        sd_sclk,
  output logic        sd_reset,
  input  logic        sd_detect,
  inout  wire  [3:0]  sd_dat,
  inout  wire         sd_cmd,
  inout  wire         PS2_CLK,
  inout  wire         PS2_DATA,
  output logic        VGA_HS_O,
  output logic        VGA_VS_O,
  output logic [3:0]  VGA_RED_O,
  output logic [3:0]  VGA_GREEN_O,
  output logic [3:0]  VGA_BLUE_O,
  output logic [31:0] core_lsu_addr,
  output logic [31:0] core_lsu_addr_dly,
  output logic [31:0] core_lsu_wdata,
  output logic [3:0]  core_lsu_be,
  output logic        ce_d,
  output logic        we_d,
  output logic        shared_sel,
  input  logic [31:0] shared_rdata
);
  localparam int TMO = 12 * CLK_DIV;
  localparam int CW  = $clog2(TMO + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_SEND = 3'd1, S_WAIT = 3'd2, S_WRITE = 3'd3,
    S_READ = 3'd4, S_CHECK = 3'd5, S_DONE = 3'd6
  } state_t;

  function automatic logic [7:0] msg_byte(input logic [1:0] i);
    case (i)
      2'd0:    return 8'h4F;
      2'd1:    return 8'h4B;
      2'd2:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  assign sd_sclk     = 1'b0;
  assign sd_reset    = 1'b1;
  assign sd_dat      = 4'bzzzz;
  assign sd_cmd      = 1'bz;
  assign PS2_CLK     = 1'bz;
  assign PS2_DATA    = 1'bz;
  assign VGA_HS_O    = 1'b1;
  assign VGA_VS_O    = 1'b1;
  assign VGA_RED_O   = 4'h0;
  assign VGA_GREEN_O = 4'h0;
  assign VGA_BLUE_O  = 4'h0;

  logic unused_ok;
  assign unused_ok = ^{from_dip[15:1], GPIO_SW_W, GPIO_SW_E, GPIO_SW_N, GPIO_SW_S,
                       sd_detect, shared_rdata[31:8]};

  state_t      state_q, state_d;
  logic [1:0]  idx_q, idx_d;
  logic [3:0]  err_q, err_d;
  logic [7:0]  byte_q, byte_d;
  logic [CW-1:0] tmr_q, tmr_d;
  logic        avail_q, tx_start, consume, fsm_inc, clr_err;
  logic [2:0]  sw_s_q;
  logic        pause, sw_rise;

  // TX: 9-bit shifter holds data plus stop bit; start bit driven on load
  logic          tx_q, tx_busy_q;
  logic [CW-1:0] tx_cnt_q;
  logic [3:0]    tx_bit_q;
  logic [8:0]    tx_sh_q;

  always_ff @(posedge msoc_clk or posedge rst) begin
    if (rst) begin
      tx_q <= 1'b1; tx_busy_q <= 1'b0; tx_cnt_q <= '0; tx_bit_q <= '0; tx_sh_q <= '0;
    end else if (tx_start) begin
      tx_q <= 1'b0; tx_busy_q <= 1'b1; tx_cnt_q <= CW'(CLK_DIV - 1);
      tx_bit_q <= '0; tx_sh_q <= {1'b1, msg_byte(idx_d)};
    end else if (tx_busy_q) begin
      if (tx_cnt_q == '0) begin
        tx_cnt_q <= CW'(CLK_DIV - 1);
        if (tx_bit_q == 4'd9) begin
          tx_busy_q <= 1'b0;
        end else begin
          tx_q     <= tx_sh_q[0];
          tx_sh_q  <= {1'b0, tx_sh_q[8:1]};
          tx_bit_q <= tx_bit_q + 4'd1;
        end
      end else begin
        tx_cnt_q <= tx_cnt_q - 1'b1;
      end
    end
  end
  assign uart_tx = tx_q;

  // RX: bit 0 is the start bit (re-checked at mid-bit), 1..8 data, 9 stop
  logic [2:0]    rx_s_q;
  logic          rx_busy_q;
  logic [CW-1:0] rx_cnt_q;
  logic [3:0]    rx_bit_q;
  logic [7:0]    rx_sh_q, rx_data_q;
  logic          rx_in, rx_sample, rx_ok, rx_ferr;

  assign rx_in     = rx_s_q[1];
  assign rx_sample = rx_busy_q && (rx_cnt_q == '0);
  assign rx_ok     = rx_sample && (rx_bit_q == 4'd9) && rx_in;
  assign rx_ferr   = rx_sample && (rx_bit_q == 4'd9) && !rx_in;

  always_ff @(posedge msoc_clk or posedge rst) begin
    if (rst) begin
      rx_s_q <= 3'b111; rx_busy_q <= 1'b0; rx_cnt_q <= '0; rx_bit_q <= '0;
      rx_sh_q <= '0; rx_data_q <= '0;
    end else begin
      rx_s_q <= {rx_s_q[1:0], uart_rx};
      if (!rx_busy_q) begin
        if (rx_s_q[2] && !rx_in) begin
          rx_busy_q <= 1'b1; rx_cnt_q <= CW'(CLK_DIV / 2 - 1); rx_bit_q <= '0;
        end
      end else if (rx_cnt_q == '0) begin
        rx_cnt_q <= CW'(CLK_DIV - 1);
        rx_bit_q <= rx_bit_q + 4'd1;
        if (rx_bit_q == 4'd0 && rx_in) rx_busy_q <= 1'b0;
        else if (rx_bit_q != 4'd0 && rx_bit_q != 4'd9) rx_sh_q <= {rx_in, rx_sh_q[7:1]};
        if (rx_bit_q == 4'd9) begin
          rx_busy_q <= 1'b0;
          if (rx_in) rx_data_q <= rx_sh_q;
        end
      end else begin
        rx_cnt_q <= rx_cnt_q - 1'b1;
      end
    end
  end

  // Bus: strobes fire only on entry to WRITE/READ so a pause cannot repeat an access
  logic [31:0] addr_q, dly_q, wdata_q, wr_addr, bus_addr;
  logic [3:0]  be_q;
  logic        ce_q, we_q, sel_q, rd_pend_q, enter_wr, enter_rd;
  logic [7:0]  rdata_q, chk_byte;

  assign enter_wr = (state_d == S_WRITE) && (state_q != S_WRITE);
  assign enter_rd = (state_d == S_READ) && (state_q != S_READ);
  assign wr_addr  = SHARED_BASE + {28'h0, idx_q, 2'b00};
  assign bus_addr = enter_wr ? wr_addr : addr_q;
  assign chk_byte = rd_pend_q ? shared_rdata[7:0] : rdata_q;
  assign pause    = from_dip[0];
  assign sw_rise  = sw_s_q[1] && !sw_s_q[2];

  always_comb begin
    state_d = state_q; idx_d = idx_q; byte_d = byte_q; tmr_d = tmr_q;
    tx_start = 1'b0; consume = 1'b0; fsm_inc = 1'b0; clr_err = 1'b0;
    case (state_q)
      S_IDLE: if (!pause) begin
        state_d = S_SEND; idx_d = 2'd0; tx_start = 1'b1;
      end
      S_SEND: if (!pause && !tx_busy_q) begin
        state_d = S_WAIT; tmr_d = CW'(TMO - 1);
      end
      S_WAIT: if (!pause) begin
        if (avail_q) begin
          byte_d = rx_data_q; consume = 1'b1; state_d = S_WRITE;
        end else if (tmr_q == '0) begin
          byte_d = 8'h00; fsm_inc = 1'b1; state_d = S_WRITE;
        end else begin
          tmr_d = tmr_q - 1'b1;
        end
      end
      S_WRITE: if (!pause) state_d = S_READ;
      S_READ:  if (!pause) state_d = S_CHECK;
      S_CHECK: if (!pause) begin
        fsm_inc = (chk_byte != msg_byte(idx_q));
        if (idx_q == 2'd3) begin
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + 2'd1; state_d = S_SEND; tx_start = 1'b1;
        end
      end
      S_DONE: if (sw_rise) begin
        state_d = S_IDLE; idx_d = 2'd0; clr_err = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  logic [4:0] err_sum;
  assign err_sum = {1'b0, err_q} + {4'b0, fsm_inc} + {4'b0, rx_ferr};
  assign err_d   = clr_err ? 4'h0 : (err_sum > 5'd15 ? 4'hF : err_sum[3:0]);

  always_ff @(posedge msoc_clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE; idx_q <= '0; err_q <= '0; byte_q <= '0; tmr_q <= '0;
      avail_q <= 1'b0; sw_s_q <= '0;
      addr_q <= '0; dly_q <= '0; wdata_q <= '0; be_q <= '0;
      ce_q <= 1'b0; we_q <= 1'b0; sel_q <= 1'b0; rd_pend_q <= 1'b0; rdata_q <= '0;
    end else begin
      state_q <= state_d; idx_q <= idx_d; err_q <= err_d; byte_q <= byte_d; tmr_q <= tmr_d;
      sw_s_q  <= {sw_s_q[1:0], GPIO_SW_C};
      if (tx_start || consume) avail_q <= 1'b0;
      else if (rx_ok)          avail_q <= 1'b1;
      ce_q  <= enter_wr || enter_rd;
      we_q  <= enter_wr;
      sel_q <= (enter_wr || enter_rd) && (bus_addr >= SHARED_BASE)
               && (bus_addr < SHARED_BASE + 32'h1000);
      if (enter_wr) begin
        addr_q <= wr_addr; wdata_q <= {24'h0, byte_d}; be_q <= 4'b0001;
      end else if (enter_rd) begin
        be_q <= 4'b1111;
      end
      dly_q     <= addr_q;
      rd_pend_q <= ce_q && !we_q;
      if (rd_pend_q) rdata_q <= shared_rdata[7:0];
    end
  end

  logic [2:0] st_bits;
  assign st_bits = state_q;

  assign u_break           = (state_q == S_DONE);
  assign to_led            = (state_q == S_DONE) ? {(err_q == 4'h0), 3'b000, err_q}
                                                 : {1'b0, st_bits, byte_q[3:0]};
  assign core_lsu_addr     = addr_q;
  assign core_lsu_addr_dly = dly_q;
  assign core_lsu_wdata    = wdata_q;
  assign core_lsu_be       = be_q;
  assign ce_d              = ce_q;
  assign we_d              = we_q;
  assign shared_sel        = sel_q;
endmodule

// File: tb/tb_minion_soc_lite.sv
// Bench for minion_soc_lite: UART loopback or idle line, 1KB RAM on the shared port,
// expected log and LED status derived from the message/error rules.
module tb_minion_soc_lite;
  localparam logic [31:0] BASE = 32'h0010_0000;

  logic        msoc_clk = 1'b0;
  logic        rst = 1'b1;
  logic        uart_tx, uart_rx, u_break;
  logic [7:0]  to_led;
  logic [15:0] from_dip = 16'h0;
  logic        sw_c = 1'b0;
  logic        sd_sclk, sd_reset, vga_hs, vga_vs;
  wire  [3:0]  sd_dat;
  wire         sd_cmd, ps2_clk, ps2_data;
  logic [3:0]  vga_r, vga_g, vga_b, core_lsu_be;
  logic [31:0] core_lsu_addr, core_lsu_addr_dly, core_lsu_wdata;
  logic        ce_d, we_d, shared_sel;
  logic [31:0] shared_rdata = 32'h0;

  int mode = 0;  // 0 loopback, 1 read data forced 0, 2 rx line idle
  int n_chk = 0, n_err = 0, ce_cnt = 0;
  logic [31:0] ram [0:255];
  logic [31:0] wa_q[$], wd_q[$];
  logic [3:0]  wb_q[$];
  logic [31:0] prev_addr;
  bit          have_prev = 0;
  logic [7:0]  msg [0:3] = '{8'h4F, 8'h4B, 8'h0D, 8'h0A};

  assign uart_rx = (mode == 2) ? 1'b1 : uart_tx;

  minion_soc_lite #(.CLK_DIV(16), .SHARED_BASE(BASE)) dut (
    .msoc_clk(msoc_clk), .rst(rst), .uart_tx(uart_tx), .uart_rx(uart_rx),
    .u_break(u_break), .to_led(to_led), .from_dip(from_dip),
    .GPIO_SW_C(sw_c), .GPIO_SW_W(1'b0), .GPIO_SW_E(1'b0), .GPIO_SW_N(1'b0), .GPIO_SW_S(1'b0),
    .sd_sclk(sd_sclk), .sd_reset(sd_reset), .sd_detect(1'b0), .sd_dat(sd_dat), .sd_cmd(sd_cmd),
    .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data), .VGA_HS_O(vga_hs), .VGA_VS_O(vga_vs),
    .VGA_RED_O(vga_r), .VGA_GREEN_O(vga_g), .VGA_BLUE_O(vga_b),
    .core_lsu_addr(core_lsu_addr), .core_lsu_addr_dly(core_lsu_addr_dly),
    .core_lsu_wdata(core_lsu_wdata), .core_lsu_be(core_lsu_be),
    .ce_d(ce_d), .we_d(we_d), .shared_sel(shared_sel), .shared_rdata(shared_rdata)
  );

  always #5 msoc_clk = ~msoc_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // behavioural RAM: read data appears the cycle after a read strobe
  always @(posedge msoc_clk) begin
    if (ce_d && we_d)
      for (int b = 0; b < 4; b++)
        if (core_lsu_be[b]) ram[core_lsu_addr[9:2]][8*b +: 8] <= core_lsu_wdata[8*b +: 8];
    if (ce_d && !we_d)
      shared_rdata <= (mode == 1) ? 32'h0 : ram[core_lsu_addr[9:2]];
  end

  always @(negedge msoc_clk) begin
    if (rst) begin
      have_prev = 0;
    end else begin
      if (have_prev) check_eq("addr_dly", core_lsu_addr_dly, prev_addr);
      prev_addr = core_lsu_addr;
      have_prev = 1;
      if (ce_d) begin
        ce_cnt++;
        check_eq("shared_sel", {31'h0, shared_sel}, 32'h1);
        if (we_d) begin
          wa_q.push_back(core_lsu_addr);
          wd_q.push_back(core_lsu_wdata);
          wb_q.push_back(core_lsu_be);
        end
      end
    end
  end

  task automatic clear_log();
    wa_q.delete(); wd_q.delete(); wb_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) @(posedge msoc_clk);
    @(negedge msoc_clk);
    clear_log();
    rst = 1'b0;
  endtask

  task automatic wait_break(input int budget);
    int n = 0;
    while (!u_break && n < budget) begin
      @(negedge msoc_clk);
      n++;
    end
    check_eq("u_break_rise", {31'h0, u_break}, 32'h1);
  endtask

  // expected log and LED status from the message and error-counting rules
  task automatic check_run(input int md, input string tag);
    int e = 0;
    logic [7:0] rxb, rb, led;
    check_eq({tag, "_nwrites"}, wa_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      rxb = (md == 2) ? 8'h00 : msg[i];
      if (md == 2) e++;
      rb = (md == 1) ? 8'h00 : rxb;
      if (rb != msg[i]) e++;
      if (i < wa_q.size()) begin
        check_eq($sformatf("%s_addr%0d", tag, i), wa_q[i], BASE + 32'(4 * i));
        check_eq($sformatf("%s_data%0d", tag, i), wd_q[i], {24'h0, rxb});
        check_eq($sformatf("%s_be%0d", tag, i), {28'h0, wb_q[i]}, 32'h1);
      end
    end
    led = (e == 0) ? 8'h80 : {4'h0, 4'((e > 15) ? 15 : e)};
    check_eq({tag, "_led"}, {24'h0, to_led}, {24'h0, led});
  endtask

  initial begin
    int c0, n;
    for (int i = 0; i < 256; i++) ram[i] = $urandom;

    repeat (3) @(posedge msoc_clk);
    @(negedge msoc_clk);
    check_eq("rst_uart_tx", {31'h0, uart_tx}, 32'h1);
    check_eq("rst_u_break", {31'h0, u_break}, 32'h0);
    check_eq("rst_led", {24'h0, to_led}, 32'h0);
    check_eq("rst_strobes", {29'h0, ce_d, we_d, shared_sel}, 32'h0);
    check_eq("rst_addr", core_lsu_addr, 32'h0);
    check_eq("rst_addr_dly", core_lsu_addr_dly, 32'h0);
    check_eq("rst_wdata", core_lsu_wdata, 32'h0);
    check_eq("rst_be", {28'h0, core_lsu_be}, 32'h0);
    check_eq("parked", {28'h0, sd_reset, sd_sclk, vga_hs, vga_vs}, 32'hB);
    clear_log();
    rst = 1'b0;
    wait_break(3000);
    check_run(0, "loop");

    // restart from DONE
    @(negedge msoc_clk);
    clear_log();
    sw_c = 1'b1;
    repeat (3) @(posedge msoc_clk);
    #1 check_eq("restart_drop", {31'h0, u_break}, 32'h0);
    repeat ($urandom_range(1, 4)) @(negedge msoc_clk);
    sw_c = 1'b0;
    wait_break(3000);
    check_run(0, "restart");

    mode = 1;
    do_reset();
    wait_break(3000);
    check_run(1, "rdata0");

    mode = 2;
    do_reset();
    wait_break(5000);
    check_run(2, "rxidle");

    // pause mid-run
    mode = 0;
    do_reset();
    repeat ($urandom_range(50, 500)) @(negedge msoc_clk);
    from_dip[0] = 1'b1;
    repeat (3) @(negedge msoc_clk);
    c0 = ce_cnt;
    repeat (500) @(negedge msoc_clk);
    check_eq("pause_no_ce", ce_cnt, c0);
    check_eq("pause_no_break", {31'h0, u_break}, 32'h0);
    from_dip[0] = 1'b0;
    wait_break(3000);
    check_run(0, "pause");

    // reset in the middle of a TX frame
    do_reset();
    n = 0;
    while (uart_tx && n < 100) begin
      @(negedge msoc_clk);
      n++;
    end
    check_eq("tx_start_seen", {31'h0, uart_tx}, 32'h0);
    repeat ($urandom_range(20, 140)) @(negedge msoc_clk);
    @(posedge msoc_clk);
    #2 rst = 1'b1;
    #1 check_eq("midrst_tx", {31'h0, uart_tx}, 32'h1);
    check_eq("midrst_ce", {31'h0, ce_d}, 32'h0);
    repeat (2) @(negedge msoc_clk);
    clear_log();
    rst = 1'b0;
    wait_break(3000);
    check_run(0, "midrst");

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
